mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_select.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter: FSM state and
// owner encodings, the full-word byte-enable constant and the latched command.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] BE_FULL = 4'b1111;

    typedef struct packed {
        logic        write;
        logic [3:0]  byteEnable;
        logic [31:0] address;
        logic [31:0] writeData;
    } memCmd_t;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between instruction and data requesters.
// Ports: iIReq, iDReq, iLastOwner in; oGrantValid, oGrantOwner out.
// Build option ARB_ROUND_ROBIN_EN: ties go to the port not granted last;
// otherwise ties go to data (fixed priority data > instruction).
module mem_arb_select
    import mem_bus_arbiter_pkg::*;
(
    input  logic   iIReq,
    input  logic   iDReq,
    input  owner_t iLastOwner,
    output logic   oGrantValid,
    output owner_t oGrantOwner
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority never looks at history.
    owner_t unusedLastOwner;
    assign unusedLastOwner = iLastOwner;
`endif

    always_comb begin
        oGrantValid = iIReq | iDReq;
        oGrantOwner = OWN_I;
        if (iIReq && iDReq) begin
`ifdef ARB_ROUND_ROBIN_EN
            oGrantOwner = (iLastOwner == OWN_I) ? OWN_D : OWN_I;
`else
            oGrantOwner = OWN_D;
`endif
        end else if (iDReq) begin
            oGrantOwner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction (read-only) and a data requester onto one memory
// port with an IDLE -> ACCESS -> RELEASE FSM and an optional wait timeout.
// Ports: iCLK/iRST; I side iIReq,iIAddress -> oIAck,oIReadData,oIErr;
// D side iDReq,iDWrite,iDByteEnable,iDAddress,iDWriteData -> oDAck,
// oDReadData,oDErr; memory oM* out, iMReadData,iMReady in; oBusy, oOwner.
// Parameter TIMEOUT_CYCLES (0 disables); build macro ARB_ROUND_ROBIN_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic [31:0] iIAddress,
    output logic        oIAck,
    output logic [31:0] oIReadData,
    output logic        oIErr,
    input  logic        iDReq,
    input  logic        iDWrite,
    input  logic [3:0]  iDByteEnable,
    input  logic [31:0] iDAddress,
    input  logic [31:0] iDWriteData,
    output logic        oDAck,
    output logic [31:0] oDReadData,
    output logic        oDErr,
    output logic        oMReadEnable,
    output logic        oMWriteEnable,
    output logic [3:0]  oMByteEnable,
    output logic [31:0] oMAddress,
    output logic [31:0] oMWriteData,
    input  logic [31:0] iMReadData,
    input  logic        iMReady,
    output logic        oBusy,
    output logic        oOwner
);

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    arbState_t   state, stateNext;
    owner_t      owner;
    memCmd_t     cmd;
    logic [31:0] cnt, cntInc;
    logic        err;
    logic [31:0] iReadData, dReadData;
    logic [31:0] capData;
    logic        grantValid;
    owner_t      grantOwner;
    logic        timeoutHit;

    mem_arb_select uSelect (
        .iIReq       (iIReq),
        .iDReq       (iDReq),
        .iLastOwner  (owner),
        .oGrantValid (grantValid),
        .oGrantOwner (grantOwner)
    );

    assign cntInc     = cnt + 32'd1;
    // Fires on the last permitted ACCESS cycle, so ACCESS lasts exactly
    // TIMEOUT_CYCLES cycles before the error release.
    assign timeoutHit = (TIMEOUT_LIM != 32'd0) && (cntInc == TIMEOUT_LIM);
    assign capData    = cmd.write ? 32'd0 : iMReadData;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext     = state;
        oMReadEnable  = 1'b0;
        oMWriteEnable = 1'b0;
        oIAck         = 1'b0;
        oDAck         = 1'b0;
        oBusy         = 1'b1;
        unique case (state)
            IDLE: begin
                oBusy = 1'b0;
                if (grantValid) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                oMReadEnable  = ~cmd.write;
                oMWriteEnable = cmd.write;
                if (iMReady || timeoutHit) begin
                    stateNext = RELEASE;
                end
            end
            RELEASE: begin
                oIAck     = (owner == OWN_I);
                oDAck     = (owner == OWN_D);
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            owner     <= OWN_I;
            cmd       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            iReadData <= '0;
            dReadData <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grantValid) begin
                        owner <= grantOwner;
                        cnt   <= '0;
                        if (grantOwner == OWN_D) begin
                            cmd <= {iDWrite, iDByteEnable,
                                    iDAddress, iDWriteData};
                        end else begin
                            cmd <= {1'b0, BE_FULL, iIAddress, 32'd0};
                        end
                    end
                end
                ACCESS: begin
                    if (iMReady) begin
                        err <= 1'b0;
                        if (owner == OWN_D) begin
                            dReadData <= capData;
                        end else begin
                            iReadData <= capData;
                        end
                    end else begin
                        cnt <= cntInc;
                        if (timeoutHit) begin
                            err <= 1'b1;
                            if (owner == OWN_D) begin
                                dReadData <= '0;
                            end else begin
                                iReadData <= '0;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oMByteEnable = cmd.byteEnable;
    assign oMAddress    = cmd.address;
    assign oMWriteData  = cmd.writeData;
    assign oIReadData   = iReadData;
    assign oDReadData   = dReadData;
    assign oIErr        = oIAck & err;
    assign oDErr        = oDAck & err;
    assign oOwner       = owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed accesses, memory responder model and
// scoreboards for memory commands and requester acknowledgements.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        own;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } cmd_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iIReq = 1'b0;
    logic [31:0] iIAddress = '0;
    logic        oIAck;
    logic [31:0] oIReadData;
    logic        oIErr;
    logic        iDReq = 1'b0;
    logic        iDWrite = 1'b0;
    logic [3:0]  iDByteEnable = '0;
    logic [31:0] iDAddress = '0;
    logic [31:0] iDWriteData = '0;
    logic        oDAck;
    logic [31:0] oDReadData;
    logic        oDErr;
    logic        oMReadEnable;
    logic        oMWriteEnable;
    logic [3:0]  oMByteEnable;
    logic [31:0] oMAddress;
    logic [31:0] oMWriteData;
    logic [31:0] iMReadData = '0;
    logic        iMReady = 1'b0;
    logic        oBusy;
    logic        oOwner;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iIReq         (iIReq),
        .iIAddress     (iIAddress),
        .oIAck         (oIAck),
        .oIReadData    (oIReadData),
        .oIErr         (oIErr),
        .iDReq         (iDReq),
        .iDWrite       (iDWrite),
        .iDByteEnable  (iDByteEnable),
        .iDAddress     (iDAddress),
        .iDWriteData   (iDWriteData),
        .oDAck         (oDAck),
        .oDReadData    (oDReadData),
        .oDErr         (oDErr),
        .oMReadEnable  (oMReadEnable),
        .oMWriteEnable (oMWriteEnable),
        .oMByteEnable  (oMByteEnable),
        .oMAddress     (oMAddress),
        .oMWriteData   (oMWriteData),
        .iMReadData    (iMReadData),
        .iMReady       (iMReady),
        .oBusy         (oBusy),
        .oOwner        (oOwner)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int   nVec = 0;
    int   nMis = 0;
    rsp_t rspQ[$];
    cmd_t cmdQ[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        nVec++;
        nMis++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic expCmd(input logic wr, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int len);
        cmd_t c;
        c.wr = wr; c.be = be; c.addr = addr; c.wdata = wdata; c.len = len;
        cmdQ.push_back(c);
    endtask

    task automatic expRsp(input logic own, input logic [31:0] data,
                          input logic err, input int at);
        rsp_t r;
        r.own = own; r.data = data; r.err = err; r.cyc = at;
        rspQ.push_back(r);
    endtask

    // Memory responder: ready after memWait wait cycles, checks commands.
    int          memWait = 0;
    logic [31:0] memData = '0;
    int          accLen = 0;
    int          curLen = 0;
    bit          inAcc = 1'b0;

    always @(negedge iCLK) begin
        cmd_t c;
        if (iRST) begin
            inAcc   = 1'b0;
            iMReady = 1'b0;
        end else if (oMReadEnable === 1'b1 || oMWriteEnable === 1'b1) begin
            if (!inAcc) begin
                inAcc  = 1'b1;
                accLen = 0;
                if (cmdQ.size() == 0) begin
                    fail("unexpected memory command");
                end else begin
                    c = cmdQ.pop_front();
                    curLen = c.len;
                    chk("cmd we", {31'd0, oMWriteEnable}, {31'd0, c.wr});
                    chk("cmd re", {31'd0, oMReadEnable}, {31'd0, ~c.wr});
                    chk("cmd be", {28'd0, oMByteEnable}, {28'd0, c.be});
                    chk("cmd addr", oMAddress, c.addr);
                    chk("cmd wdata", oMWriteData, c.wdata);
                end
            end
            accLen++;
            iMReady    = (accLen == memWait + 1);
            iMReadData = memData;
        end else begin
            if (inAcc) chk("enable cycles", 32'(accLen), 32'(curLen));
            inAcc   = 1'b0;
            iMReady = 1'b0;
        end
    end

    // Ack monitor.
    always @(negedge iCLK) begin
        rsp_t r;
        if (iRST !== 1'b1 && (oIAck === 1'b1 || oDAck === 1'b1)) begin
            if (oIAck && oDAck) begin
                fail("both acks");
            end else if (rspQ.size() == 0) begin
                fail("unexpected ack");
            end else begin
                r = rspQ.pop_front();
                chk("ack owner", {31'd0, oDAck}, {31'd0, r.own});
                chk("ack cycle", 32'(cyc), 32'(r.cyc));
                if (r.own) begin
                    chk("D rdata", oDReadData, r.data);
                    chk("D err", {31'd0, oDErr}, {31'd0, r.err});
                end else begin
                    chk("I rdata", oIReadData, r.data);
                    chk("I err", {31'd0, oIErr}, {31'd0, r.err});
                end
            end
        end
    end

    task automatic reqI(input logic [31:0] addr);
        int n;
        iIReq = 1'b1;
        iIAddress = addr;
        n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while (oIAck !== 1'b1 && n < 100);
        if (oIAck !== 1'b1) fail("I ack never came");
        @(posedge iCLK);
        #1 iIReq = 1'b0;
    endtask

    task automatic reqD(input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        iDReq = 1'b1;
        iDWrite = wr;
        iDByteEnable = be;
        iDAddress = addr;
        iDWriteData = wdata;
        n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while (oDAck !== 1'b1 && n < 100);
        if (oDAck !== 1'b1) fail("D ack never came");
        @(posedge iCLK);
        #1 iDReq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        @(posedge iCLK);
        #1;
        chk("rst busy", {31'd0, oBusy}, 32'd0);
        chk("rst owner", {31'd0, oOwner}, 32'd0);
        chk("rst acks", {30'd0, oIAck, oDAck}, 32'd0);
        chk("rst enables", {30'd0, oMReadEnable, oMWriteEnable}, 32'd0);
        chk("rst I rdata", oIReadData, 32'd0);
        chk("rst D rdata", oDReadData, 32'd0);
        chk("rst maddr", oMAddress, 32'd0);
        @(posedge iCLK);
        #1 iRST = 1'b0;

        // Instruction read, zero wait.
        @(posedge iCLK);
        #1 memWait = 0;
        memData = 32'h00500093;
        expCmd(1'b0, 4'hF, 32'h00400000, 32'd0, 1);
        expRsp(1'b0, 32'h00500093, 1'b0, cyc + 2);
        reqI(32'h00400000);

        // Data write, two wait cycles.
        @(posedge iCLK);
        #1 memWait = 2;
        memData = 32'h99999999;
        expCmd(1'b1, 4'b0011, 32'h10010004, 32'hCAFEBABE, 3);
        expRsp(1'b1, 32'd0, 1'b0, cyc + 4);
        reqD(1'b1, 4'b0011, 32'h10010004, 32'hCAFEBABE);
        chk("I rdata held", oIReadData, 32'h00500093);

        // Data read, one wait cycle.
        @(posedge iCLK);
        #1 memWait = 1;
        memData = 32'h12345678;
        expCmd(1'b0, 4'b1010, 32'h10010008, 32'd0, 2);
        expRsp(1'b1, 32'h12345678, 1'b0, cyc + 3);
        reqD(1'b0, 4'b1010, 32'h10010008, 32'd0);
        chk("owner data", {31'd0, oOwner}, 32'd1);

        // Timeout after 4 ACCESS cycles, then a normal access.
        @(posedge iCLK);
        #1 memWait = 1000;
        memData = 32'h77777777;
        expCmd(1'b0, 4'hF, 32'h20000000, 32'd0, 4);
        expRsp(1'b1, 32'd0, 1'b1, cyc + 5);
        reqD(1'b0, 4'hF, 32'h20000000, 32'd0);
        @(posedge iCLK);
        #1 memWait = 0;
        memData = 32'hA5A50001;
        expCmd(1'b0, 4'hF, 32'h20000004, 32'd0, 1);
        expRsp(1'b1, 32'hA5A50001, 1'b0, cyc + 2);
        reqD(1'b0, 4'hF, 32'h20000004, 32'd0);

        // Instruction read after data; data side must hold.
        @(posedge iCLK);
        #1 memWait = 0;
        memData = 32'h00A00113;
        expCmd(1'b0, 4'hF, 32'h00400008, 32'd0, 1);
        expRsp(1'b0, 32'h00A00113, 1'b0, cyc + 2);
        reqI(32'h00400008);
        chk("owner instr", {31'd0, oOwner}, 32'd0);
        chk("D rdata held", oDReadData, 32'hA5A50001);

        // Reset in the middle of an access: no ack, everything cleared.
        @(posedge iCLK);
        #1 memWait = 1000;
        expCmd(1'b1, 4'hF, 32'h10010020, 32'h11223344, 0);
        iDReq = 1'b1;
        iDWrite = 1'b1;
        iDByteEnable = 4'hF;
        iDAddress = 32'h10010020;
        iDWriteData = 32'h11223344;
        @(posedge iCLK);
        @(posedge iCLK);
        #1 chk("abort in access", {31'd0, oMWriteEnable}, 32'd1);
        #1 iRST = 1'b1;
        #1;
        chk("mid rst enables", {30'd0, oMReadEnable, oMWriteEnable}, 32'd0);
        chk("mid rst busy/owner", {30'd0, oBusy, oOwner}, 32'd0);
        chk("mid rst acks/errs", {28'd0, oIAck, oDAck, oIErr, oDErr}, 32'd0);
        chk("mid rst maddr", oMAddress, 32'd0);
        chk("mid rst mwdata", oMWriteData, 32'd0);
        chk("mid rst mbe", {28'd0, oMByteEnable}, 32'd0);
        chk("mid rst I rdata", oIReadData, 32'd0);
        chk("mid rst D rdata", oDReadData, 32'd0);
        iDReq = 1'b0;
        iDWrite = 1'b0;
        @(posedge iCLK);
        #1 iRST = 1'b0;
        repeat (6) @(posedge iCLK);

        // Two ties: data wins each time, instruction follows.
        for (int t = 0; t < 2; t++) begin
            @(posedge iCLK);
            #1 memWait = 0;
            memData = (t == 0) ? 32'h00A00113 : 32'h00000513;
            k = cyc;
            expCmd(1'b1, 4'b1100, 32'h10010010 + 32'(t), 32'h0BADF00D, 1);
            expCmd(1'b0, 4'hF, 32'h0040000C + 32'(4 * t), 32'd0, 1);
            expRsp(1'b1, 32'd0, 1'b0, k + 2);
            expRsp(1'b0, memData, 1'b0, k + 5);
            fork
                reqD(1'b1, 4'b1100, 32'h10010010 + 32'(t), 32'h0BADF00D);
                reqI(32'h0040000C + 32'(4 * t));
            join
        end

        repeat (4) @(posedge iCLK);
        #1;
        chk("acks outstanding", 32'(rspQ.size()), 32'd0);
        chk("cmds outstanding", 32'(cmdQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
